// File: rtl/collatz_stepper.sv
// Sequential Collatz step counter behind a valid/ready handshake.
// One Collatz step is taken per clock; the result is the step count plus an error flag.
module collatz_stepper #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out0,
    output logic         out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] x;
    logic [N-1:0] cnt;
    logic [N+1:0] x_wide;
    logic [N+1:0] tx;
    logic         tx_ovf;
    logic         cnt_max;
    logic         x_one;

    // 3x+1 is formed two bits wider so overflow past N bits is visible
    assign x_wide  = {2'b00, x};
    assign tx      = (x_wide << 1) + x_wide + (N+2)'(1);
    assign tx_ovf  = |tx[N+1:N];
    assign cnt_max = &cnt;
    assign x_one   = (x == N'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            x       <= '0;
            cnt     <= '0;
            out0    <= '0;
            out_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x   <= in0;
                        cnt <= '0;
                        if (in0 == '0) begin
                            out0    <= '0;
                            out_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (x_one) begin
                        out0    <= cnt;
                        out_err <= 1'b0;
                        state   <= DONE;
                    end else if (cnt_max) begin
                        // step budget exhausted: saturate rather than wrap
                        out0    <= cnt;
                        out_err <= 1'b1;
                        state   <= DONE;
                    end else if (x[0]) begin
                        if (tx_ovf) begin
                            out0    <= cnt;
                            out_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            x   <= tx[N-1:0];
                            cnt <= cnt + N'(1);
                        end
                    end else begin
                        x   <= x >> 1;
                        cnt <= cnt + N'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
